fd_buffer: RTL and testbench

FD_BUFFER -- requirements
Module: fd_buffer

---
 rtl/fd_buffer.sv | 168 ++++++++++++++++
 tb/tb_fd_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fd_buffer.sv
// -----------------------------------------------------------------------------
// fd_buffer -- fetch/decode pipeline buffer that assembles one-word and
// two-word (opcode + immediate) instructions.
//
// An opcode whose top bit is set is followed by an immediate word. The opcode
// and its PC are held until the immediate arrives. The pair is then presented
// to decode in a single cycle. All outputs are registered, with one cycle of
// latency.
//
// Per-cycle priority:
//   reset (active-low) > enable=0 (freeze) > flush > stall > normal operation
//
// Handshake: there is no backpressure. The word on instr_in is consumed on a
// rising edge when all of the following hold:
//   - instr_valid_in=1
//   - enable=1
//   - flush=0
//   - stall=0
// Decode treats valid_out=1 as one complete instruction for that cycle. When
// valid_out=0, the cycle is a bubble.
//
// Parameters:
//   INSTR_W  instruction/immediate word width
//   PC_W     program counter width
//   NOP      instruction word driven on bubbles
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   enable         stage enable; 0 freezes every register
//   flush          drop the stage contents (including a half-built pair)
//   stall          hold the stage contents and ignore instr_in
//   instr_in       fetched word (opcode or immediate)
//   instr_valid_in instr_in/pc_in are valid
//   pc_in          address of instr_in
//   instr_out      opcode presented to decode
//   imm_out        immediate paired with instr_out (0 when none)
//   pc_out         PC of the opcode word
//   valid_out      decode-side valid (0 = bubble)
//   imm_pending    FSM state view: 1 while waiting for an immediate
//   flush_count    saturating count of accepted flushes
// -----------------------------------------------------------------------------
module fd_buffer #(
  parameter int                 INSTR_W = 16,
  parameter int                 PC_W    = 32,
  parameter logic [INSTR_W-1:0] NOP     = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               flush,
  input  logic               stall,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] imm_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               valid_out,
  output logic               imm_pending,
  output logic [7:0]         flush_count
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_IMM = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] hold_op_q, hold_op_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;

  logic [INSTR_W-1:0] instr_d;
  logic [INSTR_W-1:0] imm_d;
  logic [PC_W-1:0]    pc_d;
  logic               valid_d;
  logic [7:0]         count_d;

  logic two_word;
  assign two_word = instr_in[INSTR_W-1];

  // Next-state and next-output logic. Every target defaults to its current
  // value, so a stall simply falls through and holds everything.
  always_comb begin
    state_d   = state_q;
    hold_op_d = hold_op_q;
    hold_pc_d = hold_pc_q;
    instr_d   = instr_out;
    imm_d     = imm_out;
    pc_d      = pc_out;
    valid_d   = valid_out;
    count_d   = flush_count;

    if (flush) begin
      // A flush abandons any half-built pair and discards this cycle's word.
      // A bubble keeps the last pc_out.
      instr_d   = NOP;
      imm_d     = '0;
      valid_d   = 1'b0;
      hold_op_d = '0;
      hold_pc_d = '0;
      state_d   = IDLE;
      if (flush_count != 8'hFF) begin
        count_d = flush_count + 8'd1;
      end
    end else if (!stall) begin
      if (!instr_valid_in) begin
        instr_d = NOP;
        imm_d   = '0;
        valid_d = 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (two_word) begin
              hold_op_d = instr_in;
              hold_pc_d = pc_in;
              instr_d   = NOP;
              imm_d     = '0;
              valid_d   = 1'b0;
              state_d   = WAIT_IMM;
            end else begin
              instr_d = instr_in;
              imm_d   = '0;
              pc_d    = pc_in;
              valid_d = 1'b1;
            end
          end
          WAIT_IMM: begin
            // Whatever arrives now is the immediate, regardless of its top bit.
            instr_d = hold_op_q;
            imm_d   = instr_in;
            pc_d    = hold_pc_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_op_q   <= '0;
      hold_pc_q   <= '0;
      instr_out   <= NOP;
      imm_out     <= '0;
      pc_out      <= '0;
      valid_out   <= 1'b0;
      imm_pending <= 1'b0;
      flush_count <= 8'd0;
    end else if (enable) begin
      state_q     <= state_d;
      hold_op_q   <= hold_op_d;
      hold_pc_q   <= hold_pc_d;
      instr_out   <= instr_d;
      imm_out     <= imm_d;
      pc_out      <= pc_d;
      valid_out   <= valid_d;
      imm_pending <= (state_d == WAIT_IMM);
      flush_count <= count_d;
    end
  end

endmodule

// File: tb/tb_fd_buffer.sv
// -----------------------------------------------------------------------------
// tb_fd_buffer -- self-checking bench for fd_buffer.
// The reference model keeps a queue that holds at most one pending opcode/PC
// pair. It applies the cycle rules directly to that queue. Every cycle the DUT
// outputs are compared against the model. Directed sequences add literal
// expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_fd_buffer;

  localparam int IW = 16;
  localparam int PW = 32;
  localparam logic [IW-1:0] NOP_W = 16'h0000;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          flush;
  logic          stall;
  logic [IW-1:0] instr_in;
  logic          instr_valid_in;
  logic [PW-1:0] pc_in;
  logic [IW-1:0] instr_out;
  logic [IW-1:0] imm_out;
  logic [PW-1:0] pc_out;
  logic          valid_out;
  logic          imm_pending;
  logic [7:0]    flush_count;

  int tests_run;
  int tests_failed;

  // Reference model state.
  logic [IW-1:0] held_op[$];
  logic [PW-1:0] held_pc[$];
  logic [IW-1:0] m_instr;
  logic [IW-1:0] m_imm;
  logic [PW-1:0] m_pc;
  logic          m_valid;
  int            m_count;

  fd_buffer #(.INSTR_W(IW), .PC_W(PW), .NOP(NOP_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .flush          (flush),
    .stall          (stall),
    .instr_in       (instr_in),
    .instr_valid_in (instr_valid_in),
    .pc_in          (pc_in),
    .instr_out      (instr_out),
    .imm_out        (imm_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out),
    .imm_pending    (imm_pending),
    .flush_count    (flush_count)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  // Comparison helper.
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the rules for one clock edge to the model.
  task automatic model_edge();
    if (!reset) begin
      held_op.delete();
      held_pc.delete();
      m_instr = NOP_W;
      m_imm   = '0;
      m_pc    = '0;
      m_valid = 1'b0;
      m_count = 0;
    end else if (!enable) begin
      // frozen
    end else if (flush) begin
      held_op.delete();
      held_pc.delete();
      m_instr = NOP_W;
      m_imm   = '0;
      m_valid = 1'b0;
      m_count = (m_count >= 255) ? 255 : m_count + 1;
    end else if (stall) begin
      // hold
    end else if (!instr_valid_in) begin
      m_instr = NOP_W;
      m_imm   = '0;
      m_valid = 1'b0;
    end else if (held_op.size() == 0) begin
      if (instr_in[IW-1]) begin
        held_op.push_back(instr_in);
        held_pc.push_back(pc_in);
        m_instr = NOP_W;
        m_imm   = '0;
        m_valid = 1'b0;
      end else begin
        m_instr = instr_in;
        m_imm   = '0;
        m_pc    = pc_in;
        m_valid = 1'b1;
      end
    end else begin
      m_instr = held_op.pop_front();
      m_pc    = held_pc.pop_front();
      m_imm   = instr_in;
      m_valid = 1'b1;
    end
  endtask

  // One cycle: update the model at the edge, then compare everything #1 later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("instr_out",   64'(instr_out),   64'(m_instr));
    check("imm_out",     64'(imm_out),     64'(m_imm));
    check("pc_out",      64'(pc_out),      64'(m_pc));
    check("valid_out",   64'(valid_out),   64'(m_valid));
    check("imm_pending", 64'(imm_pending), 64'(held_op.size() != 0));
    check("flush_count", 64'(flush_count), 64'(m_count));
  endtask

  task automatic drive(input logic en, input logic fl, input logic st,
                       input logic v, input logic [IW-1:0] w, input logic [PW-1:0] pc);
    enable         = en;
    flush          = fl;
    stall          = st;
    instr_valid_in = v;
    instr_in       = w;
    pc_in          = pc;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_instr = NOP_W; m_imm = '0; m_pc = '0; m_valid = 1'b0; m_count = 0;
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0);

    // Reset.
    step();
    step();
    check("rst_instr", 64'(instr_out), 64'h0);
    check("rst_valid", 64'(valid_out), 64'h0);
    check("rst_count", 64'(flush_count), 64'h0);
    reset = 1'b1;

    // One-word opcode.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 32'h10);
    step();
    check("ow_instr", 64'(instr_out), 64'h1234);
    check("ow_imm",   64'(imm_out),   64'h0);
    check("ow_pc",    64'(pc_out),    64'h10);
    check("ow_valid", 64'(valid_out), 64'h1);

    // Stall for 3 cycles: the outputs must hold.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 16'(16'h0100 + i), 32'h11 + i);
      step();
      check("stall_instr", 64'(instr_out), 64'h1234);
      check("stall_pc",    64'(pc_out),    64'h10);
      check("stall_valid", 64'(valid_out), 64'h1);
    end

    // Two-word opcode.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h8101, 32'h20);
    step();
    check("tw1_valid",   64'(valid_out),   64'h0);
    check("tw1_pending", 64'(imm_pending), 64'h1);
    check("tw1_instr",   64'(instr_out),   64'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h00FF, 32'h21);
    step();
    check("tw2_instr",   64'(instr_out),   64'h8101);
    check("tw2_imm",     64'(imm_out),     64'h00FF);
    check("tw2_pc",      64'(pc_out),      64'h20);
    check("tw2_valid",   64'(valid_out),   64'h1);
    check("tw2_pending", 64'(imm_pending), 64'h0);

    // Flush while waiting for an immediate.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h8101, 32'h30);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0042, 32'h31);
    step();
    check("fl_valid",   64'(valid_out),   64'h0);
    check("fl_pending", 64'(imm_pending), 64'h0);
    check("fl_count",   64'(flush_count), 64'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0042, 32'h32);
    step();
    check("fl_next_instr", 64'(instr_out), 64'h0042);
    check("fl_next_imm",   64'(imm_out),   64'h0);
    check("fl_next_pc",    64'(pc_out),    64'h32);
    check("fl_next_valid", 64'(valid_out), 64'h1);

    // Flush together with stall: the flush wins.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0007, 32'h33);
    step();
    check("flst_valid", 64'(valid_out),   64'h0);
    check("flst_count", 64'(flush_count), 64'h2);

    // enable=0 with flush=1: nothing changes.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h1111, 32'h40);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h5555, 32'h41);
    step();
    check("dis_instr", 64'(instr_out),   64'h1111);
    check("dis_valid", 64'(valid_out),   64'h1);
    check("dis_count", 64'(flush_count), 64'h2);

    // Reset while waiting for an immediate, with enable, flush and stall in play.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h8101, 32'h50);
    step();
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h00AA, 32'h51);
    step();
    check("rw_pending", 64'(imm_pending), 64'h0);
    check("rw_pc",      64'(pc_out),      64'h0);
    check("rw_count",   64'(flush_count), 64'h0);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0042, 32'h60);
    step();
    check("rw_next_instr", 64'(instr_out), 64'h0042);
    check("rw_next_imm",   64'(imm_out),   64'h0);
    check("rw_next_valid", 64'(valid_out), 64'h1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      drive(($urandom_range(0, 9) != 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 3) != 0),
            16'($urandom),
            32'($urandom));
      step();
    end
    reset = 1'b1;

    // Flush counter saturation.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'($urandom), 32'($urandom));
      step();
    end
    check("sat_count", 64'(flush_count), 64'hFF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
